// File: rtl/pixel_stream_decoder.sv
// Assembles R,G,B byte triples from the UART stream into framebuffer writes.
// An idle gap realigns the stream to pixel (0,0).
module pixel_stream_decoder #(
  parameter int X_RES        = 32,
  parameter int Y_RES        = 16,
  parameter int IDLE_TIMEOUT = 4800,
  parameter int TIMER_WIDTH  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_strobe,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       strobe,
  output logic       frame_done,
  output logic       resync
);

  localparam int XW = (X_RES > 1) ? $clog2(X_RES) : 1;
  localparam int YW = (Y_RES > 1) ? $clog2(Y_RES) : 1;

  typedef enum logic [1:0] {
    CH_R,
    CH_G,
    CH_B
  } ch_t;

  ch_t                   ch;
  ch_t                   ch_next;
  logic [XW-1:0]         pos_x;
  logic [YW-1:0]         pos_y;
  logic [TIMER_WIDTH-1:0] timer;
  logic [7:0]            r_hold;
  logic [7:0]            g_hold;

  logic pixel_done;
  logic timeout_hit;
  logic last_x;
  logic last_y;

  assign pixel_done  = rx_strobe && (ch == CH_B);
  assign timeout_hit = !rx_strobe &&
                       (timer == TIMER_WIDTH'(IDLE_TIMEOUT - 1));
  assign last_x      = (pos_x == XW'(X_RES - 1));
  assign last_y      = (pos_y == YW'(Y_RES - 1));

  always_ff @(posedge clk) begin
    if (reset) ch <= CH_R;
    else       ch <= ch_next;
  end

  always_comb begin
    ch_next = ch;
    if (rx_strobe) begin
      unique case (ch)
        CH_R:    ch_next = CH_G;
        CH_G:    ch_next = CH_B;
        CH_B:    ch_next = CH_R;
        default: ch_next = CH_R;
      endcase
    end else if (timeout_hit) begin
      ch_next = CH_R;
    end
  end

  // Timer saturates so the resync action fires once per gap.
  always_ff @(posedge clk) begin
    if (reset)
      timer <= '0;
    else if (rx_strobe)
      timer <= '0;
    else if (timer != TIMER_WIDTH'(IDLE_TIMEOUT))
      timer <= timer + TIMER_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_x <= '0;
      pos_y <= '0;
    end else if (pixel_done) begin
      if (last_x) begin
        pos_x <= '0;
        pos_y <= last_y ? '0 : pos_y + YW'(1);
      end else begin
        pos_x <= pos_x + XW'(1);
      end
    end else if (timeout_hit) begin
      pos_x <= '0;
      pos_y <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold <= '0;
      g_hold <= '0;
    end else if (rx_strobe) begin
      if (ch == CH_R) r_hold <= rx_data;
      if (ch == CH_G) g_hold <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r          <= '0;
      g          <= '0;
      b          <= '0;
      x          <= '0;
      y          <= '0;
      strobe     <= 1'b0;
      frame_done <= 1'b0;
      resync     <= 1'b0;
    end else begin
      strobe     <= pixel_done;
      frame_done <= pixel_done && last_x && last_y;
      resync     <= timeout_hit && (ch != CH_R);
      if (pixel_done) begin
        r <= r_hold;
        g <= g_hold;
        b <= rx_data;
        x <= 8'(pos_x);
        y <= 8'(pos_y);
      end
    end
  end

endmodule
